// File: rtl/trap_defs.sv
// Shared definitions for the machine-mode trap sequencer:
// FSM encoding, interrupt cause codes, mtvec modes, exception codes.
package trap_defs;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP_WR,
        ST_MRET_WR,
        ST_REDIR
    } state_t;

    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;
    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    localparam logic [3:0] EXC_INSN_MISALIGN = 4'd0;
    localparam logic [3:0] EXC_INSN_FAULT    = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL       = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT    = 4'd3;
    localparam logic [3:0] EXC_LOAD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_STORE_FAULT   = 4'd7;
    localparam logic [3:0] EXC_ECALL_M       = 4'd11;

endpackage

// File: rtl/trap_irq_sel.sv
// Combinational machine interrupt arbiter, priority MEI > MSI > MTI.
// Produces an any-enabled-pending flag and the interrupt mcause word.
module trap_irq_sel
    import trap_defs::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  i_meip,
    input  logic                  i_meie,
    input  logic                  i_msip,
    input  logic                  i_msie,
    input  logic                  i_mtip,
    input  logic                  i_mtie,
    output logic                  o_take,
    output logic [WORD_WIDTH-1:0] o_cause
);

    logic       w_mei;
    logic       w_msi;
    logic       w_mti;
    logic [3:0] w_code;

    assign w_mei = i_meip & i_meie;
    assign w_msi = i_msip & i_msie;
    assign w_mti = i_mtip & i_mtie;

    always_comb begin
        w_code = 4'd0;
        if (w_mei) begin
            w_code = IRQ_CODE_MEI;
        end else if (w_msi) begin
            w_code = IRQ_CODE_MSI;
        end else if (w_mti) begin
            w_code = IRQ_CODE_MTI;
        end
    end

    assign o_take  = w_mei | w_msi | w_mti;
    assign o_cause = {1'b1, {(WORD_WIDTH-5){1'b0}}, w_code};

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates interrupts/exceptions/mret at the
// ROB head, strobes the CSR file, then flushes and redirects fetch. Build macro: TRAP_CTRL_VECTORED_EN.
module trap_ctrl
    import trap_defs::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rob_head_valid,
    input  logic                  rob_head_ready,
    input  logic [PC_WIDTH-1:0]   rob_head_pc,
    input  logic                  rob_head_exc,
    input  logic [3:0]            rob_head_exc_code,
    input  logic [WORD_WIDTH-1:0] rob_head_exc_tval,
    input  logic                  rob_head_mret,
    output logic                  commit_allow,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [PC_WIDTH-1:0]   redirect_pc,
    input  logic                  redirect_ready,
    input  logic                  csr_mstatus_mie,
    input  logic                  csr_mie_meie,
    input  logic                  csr_mie_mtie,
    input  logic                  csr_mie_msie,
    input  logic                  csr_mip_meip,
    input  logic                  csr_mip_mtip,
    input  logic                  csr_mip_msip,
    input  logic [29:0]           csr_mtvec_base,
    input  logic [1:0]            csr_mtvec_mode,
    input  logic [PC_WIDTH-1:0]   csr_mepc_pc,
    output logic                  mstatus_mie_clear_en,
    output logic                  mstatus_mie_set_en,
    output logic                  mepc_set_en,
    output logic                  mcause_set_en,
    output logic                  mtval_set_en,
    output logic [PC_WIDTH-1:0]   mepc_set_pc,
    output logic [WORD_WIDTH-1:0] mcause_set_cause,
    output logic [WORD_WIDTH-1:0] mtval_set_tval
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [WORD_WIDTH-1:0] r_cause;
    logic [WORD_WIDTH-1:0] r_tval;
    logic                  r_irq;
    logic                  r_to_mepc;
    logic                  r_first;

    logic                  w_irq_any;
    logic [WORD_WIDTH-1:0] w_irq_cause;
    logic                  w_irq_take;
    logic                  w_exc_take;
    logic                  w_mret_take;
    logic [PC_WIDTH-1:0]   w_base_pc;
    logic [PC_WIDTH-1:0]   w_vec_pc;

    trap_irq_sel #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_irq_sel (
        .i_meip  (csr_mip_meip),
        .i_meie  (csr_mie_meie),
        .i_msip  (csr_mip_msip),
        .i_msie  (csr_mie_msie),
        .i_mtip  (csr_mip_mtip),
        .i_mtie  (csr_mie_mtie),
        .o_take  (w_irq_any),
        .o_cause (w_irq_cause)
    );

    assign w_irq_take  = w_irq_any & csr_mstatus_mie & rob_head_valid;
    assign w_exc_take  = rob_head_valid & rob_head_ready & rob_head_exc;
    assign w_mret_take = rob_head_valid & rob_head_ready & rob_head_mret;

    assign w_base_pc = PC_WIDTH'({csr_mtvec_base, 2'b00});

`ifdef TRAP_CTRL_VECTORED_EN
    assign w_vec_pc = (r_irq && csr_mtvec_mode == MTVEC_VECTORED)
                    ? w_base_pc + PC_WIDTH'({r_cause[3:0], 2'b00})
                    : w_base_pc;
`else
    logic w_unused_mode;
    assign w_unused_mode = ^{csr_mtvec_mode, r_irq};
    assign w_vec_pc      = w_base_pc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_cause   <= '0;
            r_tval    <= '0;
            r_irq     <= 1'b0;
            r_to_mepc <= 1'b0;
            r_first   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Flush qualifies only the REDIR cycle entered from a write state
            r_first <= (r_state != ST_REDIR);
            if (r_state == ST_IDLE) begin
                if (w_irq_take) begin
                    r_pc      <= rob_head_pc;
                    r_cause   <= w_irq_cause;
                    r_tval    <= '0;
                    r_irq     <= 1'b1;
                    r_to_mepc <= 1'b0;
                end else if (w_exc_take) begin
                    r_pc      <= rob_head_pc;
                    r_cause   <= WORD_WIDTH'(rob_head_exc_code);
                    r_tval    <= rob_head_exc_tval;
                    r_irq     <= 1'b0;
                    r_to_mepc <= 1'b0;
                end else if (w_mret_take) begin
                    r_irq     <= 1'b0;
                    r_to_mepc <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        flush                = 1'b0;
        redirect_valid       = 1'b0;
        redirect_pc          = '0;
        mstatus_mie_clear_en = 1'b0;
        mstatus_mie_set_en   = 1'b0;
        mepc_set_en          = 1'b0;
        mcause_set_en        = 1'b0;
        mtval_set_en         = 1'b0;
        mepc_set_pc          = '0;
        mcause_set_cause     = '0;
        mtval_set_tval       = '0;
        commit_allow         = ~rst & (r_state == ST_IDLE) & ~w_irq_take
                             & ~(rob_head_ready & rob_head_exc);
        case (r_state)
            ST_IDLE: begin
                if (w_irq_take || w_exc_take) begin
                    w_state_nxt = ST_TRAP_WR;
                end else if (w_mret_take) begin
                    w_state_nxt = ST_MRET_WR;
                end
            end
            ST_TRAP_WR: begin
                mepc_set_en          = 1'b1;
                mcause_set_en        = 1'b1;
                mtval_set_en         = 1'b1;
                mstatus_mie_clear_en = 1'b1;
                mepc_set_pc          = r_pc;
                mcause_set_cause     = r_cause;
                mtval_set_tval       = r_tval;
                w_state_nxt          = ST_REDIR;
            end
            ST_MRET_WR: begin
                mstatus_mie_set_en = 1'b1;
                w_state_nxt        = ST_REDIR;
            end
            ST_REDIR: begin
                flush          = r_first;
                redirect_valid = 1'b1;
                redirect_pc    = r_to_mepc ? csr_mepc_pc : w_vec_pc;
                if (redirect_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
